// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner:
// FSM state enum, key map, column drive helper, row priority helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   // Column 0 driven low; the other columns follow by rotation.
   localparam logic [3:0] COL_RESET = 4'b1110;

   // KEYMAP[row][col] gives the hex code printed on the key.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Rotating the reset pattern keeps exactly one column low for any c.
   function automatic logic [3:0] col_drive(input logic [1:0] c);
      logic [7:0] d;
      d = {COL_RESET, COL_RESET} << c;
      return d[7:4];
   endfunction

   // Lowest-index low row wins when several rows are low.
   function automatic logic [1:0] low_row(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd3;
      if (!r[2]) idx = 2'd2;
      if (!r[1]) idx = 2'd1;
      if (!r[0]) idx = 2'd0;
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer with synchronous reset.
// Ports: clk, reset, d (async input), q (synchronized output).
module sync2 #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and two-digit
// history. Ports: clk, reset (sync, active-high), rows (active-low, async),
// cols (one-hot-low drive), key, key_valid (1-cycle strobe), s0/s1 digits.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 1000,
   parameter int DEBOUNCE_TICKS = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key,
   output logic       key_valid,
   output logic [3:0] s0,
   output logic [3:0] s1
);

   localparam int MAX_TICKS =
      (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
   localparam int CW = $clog2(MAX_TICKS) + 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

   logic [3:0]    rows_s;
   state_t        state, next_state;
   logic [CW-1:0] cnt, cnt_next;
   logic [1:0]    col, col_next;
   logic [1:0]    row, row_next;
   logic          accept;
   logic          row_low;

   sync2 #(
      .WIDTH     (4),
      .RESET_VAL (4'b1111)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rows_s)
   );

   assign cols    = col_drive(col);
   assign row_low = ~rows_s[row];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         cnt       <= '0;
         col       <= 2'd0;
         row       <= 2'd0;
         key       <= 4'h0;
         key_valid <= 1'b0;
         s0        <= 4'h0;
         s1        <= 4'h0;
      end else begin
         state     <= next_state;
         cnt       <= cnt_next;
         col       <= col_next;
         row       <= row_next;
         key_valid <= accept;
         if (accept) begin
            key <= KEYMAP[row][col];
            s0  <= KEYMAP[row][col];
            s1  <= s0;
         end
      end
   end

   // Counter is cleared on every state change, so it only ever counts up
   // to its limit and never wraps.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      col_next   = col;
      row_next   = row;
      accept     = 1'b0;
      unique case (state)
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_next = '0;
               if (&rows_s) begin
                  col_next = col + 2'd1;
               end else begin
                  row_next   = low_row(rows_s);
                  next_state = DEBOUNCE;
               end
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         DEBOUNCE: begin
            if (!row_low) begin
               next_state = SCAN;
               col_next   = col + 2'd1;
               cnt_next   = '0;
            end else if (cnt == DEB_LAST) begin
               next_state = HELD;
               cnt_next   = '0;
               accept     = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         HELD: begin
            if (!row_low) begin
               next_state = RELEASE;
               cnt_next   = '0;
            end
         end
         RELEASE: begin
            if (row_low) begin
               next_state = HELD;
               cnt_next   = '0;
            end else if (cnt == DEB_LAST) begin
               next_state = SCAN;
               col_next   = col + 2'd1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            next_state = SCAN;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_TICKS=8.
// A small keypad model pulls the pressed rows low while its column is driven.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key;
   logic       key_valid;
   logic [3:0] s0;
   logic [3:0] s1;

   logic       press_en;
   logic [3:0] press_mask;
   logic [1:0] press_col;

   int checks  = 0;
   int errors  = 0;
   int strobes = 0;
   int base;

   keypad_scanner #(
      .SCAN_TICKS     (4),
      .DEBOUNCE_TICKS (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rows      (rows),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid),
      .s0        (s0),
      .s1        (s1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rows = (press_en && (cols[press_col] == 1'b0)) ? ~press_mask : 4'hF;

   always @(negedge clk) if (key_valid === 1'b1) strobes++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cols(input logic [3:0] exp, input int budget,
                            input string tag);
      int n;
      n = 0;
      while (cols !== exp && n < budget) begin
         tick();
         n++;
      end
      check(tag, cols, exp);
   endtask

   task automatic wait_kv(input int budget, input string tag);
      int n;
      n = 0;
      while (key_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, key_valid, 1'b1);
   endtask

   initial begin
      logic [3:0] e;
      reset      = 1'b1;
      press_en   = 1'b0;
      press_mask = 4'h0;
      press_col  = 2'd0;
      tick(); tick(); tick();
      check("rst_cols", cols, 4'b1110);
      check("rst_key", key, 4'h0);
      check("rst_kv", key_valid, 1'b0);
      check("rst_s0", s0, 4'h0);
      check("rst_s1", s1, 4'h0);

      // Idle scan: each column held for 4 cycles
      reset = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         e = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
         check("idle_cols", cols, e);
         check("idle_kv", key_valid, 1'b0);
      end

      // Key 5: row1 at col1
      base       = strobes;
      press_mask = 4'b0010;
      press_col  = 2'd1;
      press_en   = 1'b1;
      wait_kv(60, "k5_strobe");
      check("k5_key", key, 4'h5);
      check("k5_s0", s0, 4'h5);
      check("k5_s1", s1, 4'h0);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("k5_hold_cols", cols, 4'b1101);
         check("k5_hold_kv", key_valid, 1'b0);
      end
      check("k5_one_strobe", strobes - base, 1);
      press_en = 1'b0;
      wait_cols(4'b1011, 30, "k5_release");

      // Key 9: row2 at col2
      press_mask = 4'b0100;
      press_col  = 2'd2;
      press_en   = 1'b1;
      wait_kv(60, "k9_strobe");
      check("k9_key", key, 4'h9);
      check("k9_s0", s0, 4'h9);
      check("k9_s1", s1, 4'h5);
      press_en = 1'b0;
      wait_cols(4'b0111, 30, "k9_release");
      check("two_strobes", strobes - base, 2);

      // Press bounce inside DEBOUNCE on key B (row1, col3)
      wait_cols(4'b1110, 30, "sync_c0");
      wait_cols(4'b0111, 30, "sync_c3");
      base       = strobes;
      press_mask = 4'b0010;
      press_col  = 2'd3;
      press_en   = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      press_en = 1'b0;
      tick();
      press_en = 1'b1;
      tick(); tick();
      check("bounce_scan_cols", cols, 4'b1110);
      check("bounce_no_strobe", strobes - base, 0);
      wait_kv(60, "kb_strobe");
      check("kb_key", key, 4'hB);
      check("kb_s0", s0, 4'hB);
      check("kb_s1", s1, 4'h9);
      tick();
      check("kb_kv_one_cycle", key_valid, 1'b0);

      // Release bounce: 5 high cycles then low again
      press_en = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      press_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("relb_cols", cols, 4'b0111);
      end
      check("relb_no_strobe", strobes - base, 1);
      press_en = 1'b0;
      wait_cols(4'b1110, 20, "relb_final_scan");
      check("relb_total", strobes - base, 1);

      // Reset in the middle of DEBOUNCE on key 5
      wait_cols(4'b1101, 30, "sync_c1");
      base       = strobes;
      press_mask = 4'b0010;
      press_col  = 2'd1;
      press_en   = 1'b1;
      tick(); tick(); tick(); tick(); tick(); tick();
      reset = 1'b1;
      tick();
      check("mid_rst_cols", cols, 4'b1110);
      check("mid_rst_kv", key_valid, 1'b0);
      check("mid_rst_key", key, 4'h0);
      check("mid_rst_s0", s0, 4'h0);
      check("mid_rst_s1", s1, 4'h0);
      reset    = 1'b0;
      press_en = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("mid_rst_no_strobe", strobes - base, 0);

      // Rows 1 and 3 low together at col0: row1 (key 4) wins
      press_mask = 4'b1010;
      press_col  = 2'd0;
      press_en   = 1'b1;
      wait_kv(60, "multi_strobe");
      check("multi_key", key, 4'h4);
      check("multi_s0", s0, 4'h4);
      check("multi_s1", s1, 4'h0);
      press_en = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("multi_one_strobe", strobes - base, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
